// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Round-robin arbiter for the single frame-buffer SRAM write
//               port, shared by four draw requesters (map loader, start-page
//               loader, game-over overlay, cursor/sprite drawer). Each word
//               is sequenced as SETUP -> WRITE (WR_CYCLES) -> HOLD. A
//               requester that keeps asking keeps the port for up to
//               MAX_BURST words, then the pointer rotates.
// Optional    : define FB_ARB_VBLANK_EN to restrict new grants and burst
//               continuation to vertical blanking (vblank_i = 1).
// Ports       : clk_i, rst_ni (async, active low)
//               vblank_i              vertical blanking indicator
//               req_i[3:0]            level write requests
//               req_addr_i/req_data_i flattened per-requester addr/data
//               ack_o[3:0]            one-cycle word-committed pulse
//               grant_id_o            current / last granted requester
//               busy_o                state is not IDLE
//               sram_addr_o, sram_dq_out_o, sram_ce_n_o, sram_we_n_o
//               words_written_o       saturating committed-word count
// Revision    : 1.0  initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int WR_CYCLES = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  vblank_i,
    input  logic [3:0]            req_i,
    input  logic [4*ADDR_W-1:0]   req_addr_i,
    input  logic [4*DATA_W-1:0]   req_data_i,
    output logic [3:0]            ack_o,
    output logic [1:0]            grant_id_o,
    output logic                  busy_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [DATA_W-1:0]     sram_dq_out_o,
    output logic                  sram_ce_n_o,
    output logic                  sram_we_n_o,
    output logic [15:0]           words_written_o
);

    localparam int WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [WCW-1:0] C_WR_LAST    = WCW'(WR_CYCLES - 1);
    localparam logic [BCW-1:0] C_BURST_LAST = BCW'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [1:0]        rr_ptr_q,  rr_ptr_d;
    logic [1:0]        grant_q,   grant_d;
    logic [BCW-1:0]    burst_q,   burst_d;
    logic [WCW-1:0]    wr_cnt_q,  wr_cnt_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic [15:0]       words_q,   words_d;

    logic [3:0]        w_elig;
    logic              w_found;
    logic [1:0]        w_win;
    logic [1:0]        w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

`ifdef FB_ARB_VBLANK_EN
    assign w_elig = req_i & {4{vblank_i}};
`else
    // vblank has no effect in this build; the AND with zero keeps it referenced.
    assign w_elig = req_i | {4{vblank_i & 1'b0}};
`endif

    // First eligible requester at or after rr_ptr, wrapping 3 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && w_elig[rr_ptr_q + 2'(i)]) begin
                w_found = 1'b1;
                w_win   = rr_ptr_q + 2'(i);
            end
        end
    end

    // IDLE latches from the round-robin winner, HOLD from the current owner.
    assign w_sel      = (state_q == S_HOLD) ? grant_q : w_win;
    assign w_sel_addr = req_addr_i[w_sel*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data_i[w_sel*DATA_W +: DATA_W];

    // State register and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd0;
            burst_q  <= '0;
            wr_cnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            words_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            burst_q  <= burst_d;
            wr_cnt_q <= wr_cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            words_q  <= words_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        burst_d  = burst_q;
        wr_cnt_d = wr_cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        words_d  = words_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d  = w_win;
                    addr_d   = w_sel_addr;
                    data_d   = w_sel_data;
                    burst_d  = '0;
                    wr_cnt_d = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                wr_cnt_d = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (wr_cnt_q == C_WR_LAST) begin
                    if (words_q != 16'hFFFF) begin
                        words_d = words_q + 16'd1;
                    end
                    state_d = S_HOLD;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            default: begin // S_HOLD
                // burst_q never exceeds MAX_BURST-1, so != is the "<" test.
                if (w_elig[grant_q] && (burst_q != C_BURST_LAST)) begin
                    addr_d  = w_sel_addr;
                    data_d  = w_sel_data;
                    burst_d = burst_q + 1'b1;
                    state_d = S_SETUP;
                end else begin
                    rr_ptr_d = grant_q + 2'd1;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // Outputs decoded from state so reset releases the strobes immediately.
    always_comb begin
        ack_o       = 4'b0000;
        sram_ce_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        busy_o      = (state_q != S_IDLE);
        case (state_q)
            S_SETUP: sram_ce_n_o = 1'b0;
            S_WRITE: begin
                sram_ce_n_o = 1'b0;
                sram_we_n_o = 1'b0;
                if (wr_cnt_q == C_WR_LAST) begin
                    ack_o = 4'b0001 << grant_q;
                end
            end
            S_HOLD:  sram_ce_n_o = 1'b0;
            default: sram_ce_n_o = 1'b1;
        endcase
    end

    assign grant_id_o      = grant_q;
    assign sram_addr_o     = addr_q;
    assign sram_dq_out_o   = data_q;
    assign words_written_o = words_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Self-checking bench for fb_write_arbiter. u_dut0 uses the
//               default parameters (WR_CYCLES=2, MAX_BURST=8); u_dut1 shares
//               the stimulus with MAX_BURST=1 for the rotation sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fb_write_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vblank;
    logic [3:0]      req;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_data;

    logic [3:0]  ack0, ack1;
    logic [1:0]  gid0, gid1;
    logic        busy0, busy1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] dq0, dq1;
    logic        ce0, ce1, we0, we1;
    logic [15:0] ww0, ww1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(2), .MAX_BURST(8)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .vblank_i(vblank), .req_i(req),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .ack_o(ack0), .grant_id_o(gid0), .busy_o(busy0),
        .sram_addr_o(addr0), .sram_dq_out_o(dq0),
        .sram_ce_n_o(ce0), .sram_we_n_o(we0), .words_written_o(ww0));

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(2), .MAX_BURST(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .vblank_i(vblank), .req_i(req),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .ack_o(ack1), .grant_id_o(gid1), .busy_o(busy1),
        .sram_addr_o(addr1), .sram_dq_out_o(dq1),
        .sram_ce_n_o(ce1), .sram_we_n_o(we1), .words_written_o(ww1));

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_g;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] def_addr(input int i);
        return AW'(32'h10000 + i * 256);
    endfunction

    function automatic logic [DW-1:0] def_data(input int i);
        return DW'(32'hA000 + i);
    endfunction

    task automatic set_word(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < 4; i++) set_word(i, def_addr(i), def_data(i));
    endtask

    // Ticks until the selected DUT shows a nonzero ack; n = -1 on timeout.
    task automatic wait_ack(input bit sel, output int n, output logic [3:0] a);
        n = -1;
        a = 4'b0000;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if ((sel ? ack1 : ack0) != 4'b0000) begin
                n = t;
                a = sel ? ack1 : ack0;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [3:0] a;
        int cnt;

        vecs[0] = '{4'b1111, 2'd3};
        vecs[1] = '{4'b1111, 2'd0};
        vecs[2] = '{4'b0101, 2'd2};
        vecs[3] = '{4'b0011, 2'd0};
        vecs[4] = '{4'b1000, 2'd3};
        vecs[5] = '{4'b0110, 2'd1};
        vecs[6] = '{4'b0011, 2'd0};
        vecs[7] = '{4'b0001, 2'd0};

        rst_n    = 1'b0;
        vblank   = 1'b0;
        req      = 4'b0000;
        req_addr = '0;
        req_data = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ack",   32'(ack0),  32'h0);
        chk("rst_grant", 32'(gid0),  32'h0);
        chk("rst_busy",  32'(busy0), 32'h0);
        chk("rst_ce_we", 32'({ce0, we0}), 32'h3);
        chk("rst_addr",  32'(addr0), 32'h0);
        chk("rst_data",  32'(dq0),   32'h0);
        chk("rst_words", 32'(ww0),   32'h0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 2, full phase trace
        set_word(2, 20'h00123, 16'hBEEF);
        req = 4'b0100;
        tick();
        chk("sw_setup_busy",  32'(busy0), 32'h1);
        chk("sw_setup_cewe",  32'({ce0, we0}), 32'h1);
        chk("sw_setup_addr",  32'(addr0), 32'h00123);
        tick();
        chk("sw_wr1_cewe", 32'({ce0, we0}), 32'h0);
        chk("sw_wr1_ack",  32'(ack0), 32'h0);
        tick();
        chk("sw_wr2_cewe", 32'({ce0, we0}), 32'h0);
        chk("sw_wr2_ack",  32'(ack0), 32'h4);
        chk("sw_wr2_data", 32'(dq0),  32'hBEEF);
        chk("sw_wr2_gid",  32'(gid0), 32'h2);
        tick();
        chk("sw_hold_cewe",  32'({ce0, we0}), 32'h1);
        chk("sw_hold_words", 32'(ww0), 32'h1);
        chk("sw_hold_ack",   32'(ack0), 32'h0);
        req = 4'b0000;
        tick();
        chk("sw_idle_busy", 32'(busy0), 32'h0);
        chk("sw_idle_cewe", 32'({ce0, we0}), 32'h3);
        chk("sw_idle_addr", 32'(addr0), 32'h00123);

        // Round-robin vectors (rr_ptr is 3 after the single write)
        set_defaults();
        for (int v = 0; v < 8; v++) begin
            req = vecs[v].req;
            wait_ack(1'b0, n, a);
            chk("tbl_latency", 32'(n), 32'd3);
            chk("tbl_ack",   32'(a),    32'(4'b0001 << vecs[v].exp_g));
            chk("tbl_grant", 32'(gid0), 32'(vecs[v].exp_g));
            chk("tbl_addr",  32'(addr0), 32'(def_addr(int'(vecs[v].exp_g))));
            chk("tbl_data",  32'(dq0),   32'(def_data(int'(vecs[v].exp_g))));
            tick();
            req = 4'b0000;
            tick();
            chk("tbl_idle", 32'(busy0), 32'h0);
        end
        chk("tbl_words", 32'(ww0), 32'd9);

        // Burst cap: requester 0 asks for 20 consecutive words
        set_word(0, 20'h20000, 16'h5000);
        req = 4'b0001;
        for (int w = 0; w < 20; w++) begin
            wait_ack(1'b0, n, a);
            chk("bst_ack",  32'(a), 32'h1);
            chk("bst_addr", 32'(addr0), 32'(20'h20000 + w));
            chk("bst_data", 32'(dq0),   32'(16'h5000 + w));
            chk("bst_interval", 32'(n), (w > 0 && (w % 8) == 0) ? 32'd4 : 32'd3);
            tick();
            if (w < 19) set_word(0, AW'(20'h20000 + w + 1), DW'(16'h5000 + w + 1));
            else req = 4'b0000;
        end
        tick();
        chk("bst_idle",  32'(busy0), 32'h0);
        chk("bst_words", 32'(ww0), 32'd29);

        // Rotation with MAX_BURST=1, all four requesting continuously
        pulse_reset();
        set_defaults();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_ack(1'b1, n, a);
            chk("rot_ack",   32'(a),    32'(4'b0001 << (k % 4)));
            chk("rot_grant", 32'(gid1), 32'(k % 4));
        end
        req = 4'b0000;
        cnt = 0;
        while ((busy0 || busy1) && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("rot_drain", 32'({busy0, busy1}), 32'h0);

        // Request dropped during WRITE: word still completes, no re-grant
        pulse_reset();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        wait_ack(1'b0, n, a);
        chk("drop_latency", 32'(n), 32'd1);
        chk("drop_ack", 32'(a), 32'h2);
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (ack0 != 4'b0000) cnt++;
        end
        chk("drop_extra_acks", 32'(cnt), 32'd0);
        chk("drop_busy",  32'(busy0), 32'h0);
        chk("drop_words", 32'(ww0), 32'd1);

        // Asynchronous reset in the middle of a write strobe
        req = 4'b1000;
        tick();
        tick();
        chk("ar_we_low", 32'(we0), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cewe", 32'({ce0, we0}), 32'h3);
        chk("ar_busy", 32'(busy0), 32'h0);
        chk("ar_ack",  32'(ack0), 32'h0);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (ack0 != 4'b0000) cnt++;
        end
        chk("ar_no_ack", 32'(cnt), 32'd0);
        chk("ar_words",  32'(ww0), 32'd0);

`ifdef FB_ARB_VBLANK_EN
        // Grants gated by vertical blanking
        vblank = 1'b0;
        req = 4'b1000;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (busy0) cnt++;
        end
        chk("vb_no_grant", 32'(cnt), 32'd0);
        vblank = 1'b1;
        tick();
        chk("vb_grant_busy", 32'(busy0), 32'h1);
        chk("vb_grant_id",   32'(gid0),  32'h3);
        tick();
        vblank = 1'b0;
        wait_ack(1'b0, n, a);
        chk("vb_ack_latency", 32'(n), 32'd1);
        chk("vb_ack", 32'(a), 32'h8);
        tick();
        tick();
        chk("vb_burst_end", 32'(busy0), 32'h0);
        req = 4'b0000;
`else
        // vblank low must not block a grant in this build
        vblank = 1'b0;
        req = 4'b1000;
        wait_ack(1'b0, n, a);
        chk("vb_ignored_latency", 32'(n), 32'd3);
        chk("vb_ignored_ack", 32'(a), 32'h8);
        tick();
        req = 4'b0000;
        tick();
        chk("vb_ignored_idle", 32'(busy0), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
